fifo_burst_reader: RTL
======================

Name: fifo_burst_reader

Overview:
- Read-side engine for the team's synchronous `fifo` block (ports `rd`/`empty`/`data_out`, registered read data one cycle after `rd`).
- On a command, pops exactly `cmd_len` words from the FIFO and presents them downstream on a valid/ready stream.
- Uses a 2-entry output buffer, so it sustains 1 word/cycle.
- Sits between the FIFO and any consumer (serializer, DMA, packetizer); it mirrors the FIFO's write-side producer.

Parameters:
- WIDTH, 8, data width; must match the FIFO `width`.
- LEN_W, 4, width of the burst length / remaining counter (max burst 2^LEN_W-1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_start  in  1  start a burst; sampled only in IDLE
- cmd_len  in  LEN_W  words to read; sampled with cmd_start
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when the last word of the burst is accepted downstream
- fifo_rd  out  1  pop request to the FIFO
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  WIDTH  FIFO read data, valid the cycle after an accepted pop
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  WIDTH  output word

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, fifo_rd=0, m_valid=0, m_data=0; remaining=0, in-flight=0, buffer occupancy=0.
- Reset mid-burst aborts the burst. In-flight and buffered words are discarded with no done pulse. Re-synchronising the FIFO is the system's job.
- States:
  - IDLE: cmd_start=1 and cmd_len!=0 → RUN; load remaining=cmd_len, busy=1 next cycle.
  - IDLE, cmd_len=0: stay IDLE; done pulses the next cycle; no pops issued.
  - RUN: pop issue rule (combinational from registered state):
    - fifo_rd = (remaining!=0) && !fifo_empty && (occ + inflight − (m_valid&&m_ready) < 2).
    - Each pop decrements remaining and sets inflight for one cycle.
    - Next cycle, fifo_data is written into the buffer.
  - RUN → DRAIN: when the pop decrementing remaining to 0 is issued.
  - DRAIN: no pops; when inflight=0 and the last buffered word is handshaken → IDLE; done=1 that cycle edge (registered pulse); busy=0.
- cmd_start while busy is ignored; no queuing.
- Latency: cmd_start sampled at edge E0 → fifo_rd high in cycle after E0 (FIFO non-empty) → m_valid high after E2.
- FIFO empty mid-burst: fifo_rd held low and the engine waits indefinitely; no timeout.
- Never pops when fifo_empty=1; never pops more than cmd_len words.
- Output buffer: 2-entry FIFO ordering.
  - m_data and m_valid are stable while m_valid && !m_ready.
  - Simultaneous capture and handshake keeps occupancy unchanged.
- Throughput: with m_ready=1 and FIFO non-empty, one word per cycle after the first.
- m_ready low: at most 2 words are buffered; pops stall via the issue rule (occupancy incl. in-flight never exceeds 2).
- Counter arithmetic is unsigned LEN_W bits; remaining never wraps (decrement only when nonzero).

Optional Feature:
- Macro: FIFO_BURST_READER_STATS_EN.
- Defined: adds output `stat_words` [15:0]. It increments on every downstream handshake (m_valid&&m_ready), saturates at 16'hFFFF, is cleared by rst, and is not cleared per burst.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package fifo_burst_reader_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2.
  - Buffer depth constant OBUF_DEPTH=2.
- One sub-module, fifo_burst_reader_obuf: 2-entry valid/ready output buffer with write strobe, occupancy output and stable-data guarantee.
- The FSM, counters and pop logic stay in the top module.

Test Plan:
- Setup: connect to `fifo` (depth 8, width 8); rst high 13 ns, then low. Preload 10,20,30 via the FIFO write port.
- Basic burst: cmd_len=3, m_ready=1 → m_data 10,20,30 on consecutive cycles; exactly 3 fifo_rd pulses; done one cycle; busy low afterwards; FIFO empty=1.
- Backpressure: preload 40,50,60,70,80; cmd_len=5; m_ready=0 for 6 cycles then 1 → at most 2 pops before stall; m_data holds 40 while stalled; output order 40..80; done once.
- Empty stall: cmd_len=4 with only 2 words present → 2 words out, fifo_rd stays 0 while empty; then write 2 more (90,A0) → remaining 2 words delivered, done.
- Corner commands: cmd_len=0 → done pulse next cycle, zero pops. cmd_start during busy → ignored; word count unchanged.
- Reset mid-burst: assert rst after the 2nd output word of a 5-word burst → all outputs 0 immediately (async); no done; a new cmd afterwards works normally.
- With FIFO_BURST_READER_STATS_EN: after the bursts above, stat_words equals total handshakes.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared FSM state type and output-buffer sizing for fifo_burst_reader.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned OBUF_DEPTH = 2;
  localparam int unsigned OCC_W      = $clog2(OBUF_DEPTH + 1);

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Command, FIFO read-port and downstream stream signals of fifo_burst_reader.
interface fifo_burst_reader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
);
  logic             cmd_start;
  logic [LEN_W-1:0] cmd_len;
  logic             busy;
  logic             done;
  logic             fifo_rd;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  cmd_start, cmd_len, fifo_empty, fifo_data, m_ready,
    output busy, done, fifo_rd, m_valid, m_data
  );

  modport slave (
    output cmd_start, cmd_len, fifo_empty, fifo_data, m_ready,
    input  busy, done, fifo_rd, m_valid, m_data
  );
endinterface

// File: rtl/fifo_burst_reader_obuf.sv
// Two-entry valid/ready output buffer; head word is held stable until accepted.
module fifo_burst_reader_obuf
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [OCC_W-1:0] count;
  logic             rd;

  assign valid = (count != '0);
  assign data  = head;
  assign occ   = count;
  assign rd    = valid && ready;

  // head is the presented word; tail only ever holds the second-oldest word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({wr_en, rd})
        2'b10: begin
          if (count == '0) begin
            head  <= wr_data;
            count <= count + OCC_W'(1);
          end else if (count == OCC_W'(1)) begin
            tail  <= wr_data;
            count <= count + OCC_W'(1);
          end
        end
        2'b01: begin
          if (count == OCC_W'(OBUF_DEPTH)) head <= tail;
          count <= count - OCC_W'(1);
        end
        2'b11: begin
          if (count == OCC_W'(OBUF_DEPTH)) begin
            head <= tail;
            tail <= wr_data;
          end else begin
            head <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops cmd_len words from a synchronous FIFO and streams them out on valid/ready.
// Define FIFO_BURST_READER_STATS_EN to add the saturating stat_words handshake counter.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  fifo_burst_reader_if.master       bus
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [15:0]               stat_words
`endif
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             inflight;
  logic             busy_q;
  logic             done_q;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   pending;
  logic             hs;
  logic             pop;

  assign hs      = bus.m_valid && bus.m_ready;
  assign pending = {1'b0, occ} + (OCC_W+1)'(inflight);
  // a word leaving this cycle frees a slot for the pop issued now
  assign pop     = (remaining != '0) && !bus.fifo_empty &&
                   (pending < (OCC_W+1)'(OBUF_DEPTH) + (OCC_W+1)'(hs));

  assign bus.fifo_rd = pop;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  fifo_burst_reader_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (bus.fifo_data),
    .valid   (bus.m_valid),
    .ready   (bus.m_ready),
    .data    (bus.m_data),
    .occ     (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      inflight  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= pop;
      if (pop) remaining <= remaining - LEN_W'(1);
      case (state)
        ST_IDLE: begin
          if (bus.cmd_start) begin
            if (bus.cmd_len != '0) begin
              state     <= ST_RUN;
              remaining <= bus.cmd_len;
              busy_q    <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pop && remaining == LEN_W'(1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!inflight && occ == OCC_W'(1) && hs) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words <= '0;
    end else if (hs && stat_words != '1) begin
      stat_words <= stat_words + 16'd1;
    end
  end
`endif

endmodule
